bg_line_renderer: RTL and testbench

BG_LINE_RENDERER -- requirements
Module: bg_line_renderer

---
 rtl/bg_line_renderer.sv | 145 ++++++++++++++
 tb/tb_bg_line_renderer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bg_line_renderer.sv
// bg_line_renderer: tile-based background scanline renderer with VRAM fetch FSM and pixel stream.
// Optional window layer enabled by defining BG_LINE_RENDERER_WINDOW_EN.
module bg_line_renderer #(
  parameter int LINE_WIDTH = 160,
  parameter int VRAM_AW    = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               drawline,
  input  logic [7:0]         line,
  input  logic [7:0]         scroll_x,
  input  logic [7:0]         scroll_y,
  input  logic               map_sel,
  input  logic               tile_sel,
  input  logic [7:0]         palette,
  output logic               vram_rd,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic [7:0]         vram_data,
  input  logic               win_en,
  input  logic [7:0]         win_x,
  input  logic [7:0]         win_y,
  input  logic               win_map_sel,
  output logic               pix_valid,
  output logic [7:0]         pix_x,
  output logic [1:0]         pix_shade,
  output logic               render_complete
);
  typedef enum logic [2:0] {IDLE, MAP, LO, HI, LOAD, PUSH, DONE} state_t;
  state_t r_st, w_nx;
  logic [7:0] r_row, r_pal, r_idx, r_lo, r_hi, r_cnt;
  logic [4:0] r_col;
  logic [2:0] r_c, r_fine;
  logic r_msel, r_tsel, r_first;
  logic w_acc, w_disc, w_win, w_last;
  logic [7:0] w_tidx;
  logic [12:0] w_tile, w_a;
  logic [1:0] w_pi;
`ifdef BG_LINE_RENDERER_WINDOW_EN
  logic r_win_ok, r_in_win, r_wmsel;
  logic [7:0] r_trig, r_line, r_wy;
  assign w_win = r_st == PUSH && r_win_ok && !r_in_win && r_cnt == r_trig;
`else
  logic w_unused;
  assign w_unused = ^{win_en, win_x, win_y, win_map_sel};
  assign w_win = 1'b0;
`endif
  assign w_acc = drawline && (r_st == IDLE || r_st == DONE);
  assign w_disc = r_first && r_c < r_fine;
  assign w_last = !w_disc && r_cnt == 8'(LINE_WIDTH - 1);
  assign w_tidx = r_st == LO ? vram_data : r_idx;
  // Low-byte address of the current tile row; the high byte is the next odd address
  assign w_tile = r_tsel ? {1'b0, w_tidx, r_row[2:0], 1'b0}
                         : 13'h1000 + {w_tidx[7], w_tidx, r_row[2:0], 1'b0};
  assign w_pi = {r_hi[3'd7 - r_c], r_lo[3'd7 - r_c]};
  assign vram_addr = VRAM_AW'(w_a);
  assign render_complete = r_st == DONE;
  always_comb begin
    w_nx = r_st;
    vram_rd = 1'b0;
    w_a = 13'd0;
    case (r_st)
      IDLE, DONE: w_nx = w_acc ? MAP : r_st;
      MAP: begin
        vram_rd = 1'b1;
        w_a = {2'b11, r_msel, r_row[7:3], r_col};
        w_nx = LO;
      end
      LO: begin
        vram_rd = 1'b1;
        w_a = w_tile;
        w_nx = HI;
      end
      HI: begin
        vram_rd = 1'b1;
        w_a = w_tile | 13'd1;
        w_nx = LOAD;
      end
      LOAD: w_nx = PUSH;
      PUSH: w_nx = w_win ? MAP : w_last ? DONE : r_c == 3'd7 ? MAP : PUSH;
      default: w_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st <= IDLE;
      pix_valid <= 1'b0;
      pix_x <= 8'd0;
      pix_shade <= 2'd0;
      r_cnt <= 8'd0;
      r_c <= 3'd0;
`ifdef BG_LINE_RENDERER_WINDOW_EN
      r_in_win <= 1'b0;
      r_win_ok <= 1'b0;
`endif
    end else begin
      r_st <= w_nx;
      pix_valid <= 1'b0;
      if (w_acc) begin
        r_row <= line + scroll_y;
        r_col <= scroll_x[7:3];
        r_fine <= scroll_x[2:0];
        r_msel <= map_sel;
        r_tsel <= tile_sel;
        r_pal <= palette;
        r_first <= 1'b1;
        r_cnt <= 8'd0;
`ifdef BG_LINE_RENDERER_WINDOW_EN
        r_in_win <= 1'b0;
        r_win_ok <= win_en && line >= win_y && {1'b0, win_x} <= 9'(LINE_WIDTH + 6);
        r_trig <= win_x < 8'd7 ? 8'd0 : win_x - 8'd7;
        r_line <= line;
        r_wy <= win_y;
        r_wmsel <= win_map_sel;
`endif
      end
      if (r_st == LO) r_idx <= vram_data;
      if (r_st == HI) r_lo <= vram_data;
      if (r_st == LOAD) begin
        r_hi <= vram_data;
        r_c <= 3'd0;
      end
      if (r_st == PUSH) begin
        r_c <= r_c + 3'd1;
        if (r_c == 3'd7) begin
          r_col <= r_col + 5'd1;
          r_first <= 1'b0;
        end
        if (w_win) begin
`ifdef BG_LINE_RENDERER_WINDOW_EN
          r_in_win <= 1'b1;
          r_col <= 5'd0;
          r_row <= r_line - r_wy;
          r_msel <= r_wmsel;
          r_first <= 1'b0;
`endif
        end else if (!w_disc) begin
          pix_valid <= 1'b1;
          pix_x <= r_cnt;
          pix_shade <= r_pal[{w_pi, 1'b0} +: 2];
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bg_line_renderer.sv
// tb_bg_line_renderer: directed self-checking bench for bg_line_renderer with a behavioural VRAM.
module tb_bg_line_renderer;
  logic clk = 0, reset = 1, drawline = 0;
  logic [7:0] line = 0, scroll_x = 0, scroll_y = 0, palette = 8'hE4;
  logic map_sel = 0, tile_sel = 1;
  logic vram_rd;
  logic [12:0] vram_addr;
  logic [7:0] vram_data = 0;
  logic win_en = 0, win_map_sel = 0;
  logic [7:0] win_x = 0, win_y = 0;
  logic pix_valid, render_complete;
  logic [7:0] pix_x;
  logic [1:0] pix_shade;
  logic [7:0] mem [0:8191];
  int n_chk = 0, n_fail = 0;
  int lat, npix, nlog, got_rc, rc0, e;
  int cap_x [0:511];
  int cap_s [0:511];
  logic [12:0] logv [0:1023];

  bg_line_renderer dut (
    .clk(clk), .reset(reset), .drawline(drawline), .line(line),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .map_sel(map_sel), .tile_sel(tile_sel),
    .palette(palette), .vram_rd(vram_rd), .vram_addr(vram_addr), .vram_data(vram_data),
    .win_en(win_en), .win_x(win_x), .win_y(win_y), .win_map_sel(win_map_sel),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_shade(pix_shade),
    .render_complete(render_complete)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (vram_rd) vram_data <= mem[vram_addr];

  // Pulses drawline and records reads and pixels until render_complete or a cycle budget
  task automatic run_line(input int poke);
    nlog = 0; npix = 0; lat = -1; got_rc = 0; rc0 = -1;
    drawline = 1;
    @(posedge clk); #1;
    for (int n = 0; n < 3000 && got_rc == 0; n++) begin
      drawline = (n == poke);
      if (n == 0) rc0 = render_complete;
      if (vram_rd) begin logv[nlog] = vram_addr; nlog++; end
      if (pix_valid) begin
        if (lat < 0) lat = n;
        cap_x[npix] = pix_x; cap_s[npix] = pix_shade; npix++;
      end
      if (render_complete) got_rc = 1;
      else begin @(posedge clk); #1; end
    end
    drawline = 0;
  endtask

  task automatic test_reset;
    drawline = 1; reset = 1;
    repeat (3) @(posedge clk); #1;
    n_chk++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid got %b want 0", pix_valid); end
    n_chk++; if (vram_rd !== 1'b0) begin n_fail++; $display("FAIL reset_vram_rd got %b want 0", vram_rd); end
    n_chk++; if (render_complete !== 1'b0) begin n_fail++; $display("FAIL reset_rc got %b want 0", render_complete); end
    n_chk++; if (pix_x !== 8'd0) begin n_fail++; $display("FAIL reset_pix_x got %0d want 0", pix_x); end
    n_chk++; if (pix_shade !== 2'd0) begin n_fail++; $display("FAIL reset_shade got %0d want 0", pix_shade); end
    n_chk++; if (vram_addr !== 13'd0) begin n_fail++; $display("FAIL reset_vram_addr got %h want 0", vram_addr); end
    drawline = 0; reset = 0;
    @(posedge clk); #1;
    n_chk++; if (vram_rd !== 1'b0) begin n_fail++; $display("FAIL reset_idle_rd got %b want 0", vram_rd); end
  endtask

  task automatic test_basic;
    scroll_x = 0; scroll_y = 0; line = 0; tile_sel = 1; map_sel = 0;
    run_line(-1);
    e = 0;
    for (int i = 0; i < npix; i++) if (cap_x[i] != i || cap_s[i] != i % 4) e++;
    n_chk++; if (got_rc !== 1) begin n_fail++; $display("FAIL basic_rc got %0d want 1", got_rc); end
    n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL basic_latency got %0d want 5", lat); end
    n_chk++; if (npix !== 160) begin n_fail++; $display("FAIL basic_npix got %0d want 160", npix); end
    n_chk++; if (e !== 0) begin n_fail++; $display("FAIL basic_seq bad %0d want 0", e); end
    n_chk++; if (nlog !== 60) begin n_fail++; $display("FAIL basic_nreads got %0d want 60", nlog); end
    n_chk++; if (logv[0] !== 13'h1800 || logv[1] !== 13'h0000 || logv[2] !== 13'h0001)
      begin n_fail++; $display("FAIL basic_addrs got %h %h %h want 1800 0000 0001", logv[0], logv[1], logv[2]); end
    n_chk++; if (logv[3] !== 13'h1801) begin n_fail++; $display("FAIL basic_col1 got %h want 1801", logv[3]); end
    @(posedge clk); #1;
    n_chk++; if (pix_valid !== 1'b0 || pix_x !== 8'd159 || render_complete !== 1'b1)
      begin n_fail++; $display("FAIL basic_hold got v%b x%0d rc%b want v0 x159 rc1", pix_valid, pix_x, render_complete); end
  endtask

  task automatic test_back_to_back;
    run_line(-1);
    n_chk++; if (rc0 !== 0) begin n_fail++; $display("FAIL b2b_rc_clear got %0d want 0", rc0); end
    n_chk++; if (lat !== 5 || npix !== 160) begin n_fail++; $display("FAIL b2b got lat %0d npix %0d want 5 160", lat, npix); end
  endtask

  task automatic test_ignore;
    run_line(100);
    e = 0;
    for (int i = 0; i < npix; i++) if (cap_x[i] != i || cap_s[i] != i % 4) e++;
    n_chk++; if (npix !== 160 || e !== 0) begin n_fail++; $display("FAIL ignore npix %0d bad %0d want 160 0", npix, e); end
    n_chk++; if (nlog !== 60) begin n_fail++; $display("FAIL ignore_nreads got %0d want 60", nlog); end
  endtask

  task automatic test_fine_scroll;
    scroll_x = 8'd2;
    run_line(-1);
    e = 0;
    for (int i = 0; i < npix; i++) if (cap_x[i] != i || cap_s[i] != (i + 2) % 4) e++;
    n_chk++; if (cap_s[0] !== 2) begin n_fail++; $display("FAIL fine_first got %0d want 2", cap_s[0]); end
    n_chk++; if (npix !== 160 || got_rc !== 1) begin n_fail++; $display("FAIL fine_count npix %0d rc %0d want 160 1", npix, got_rc); end
    n_chk++; if (lat !== 7) begin n_fail++; $display("FAIL fine_latency got %0d want 7", lat); end
    n_chk++; if (e !== 0) begin n_fail++; $display("FAIL fine_seq bad %0d want 0", e); end
    n_chk++; if (nlog !== 63) begin n_fail++; $display("FAIL fine_nreads got %0d want 63", nlog); end
    scroll_x = 0;
  endtask

  task automatic test_map_wrap;
    scroll_x = 8'hF8;
    run_line(-1);
    n_chk++; if (logv[0] !== 13'h181F) begin n_fail++; $display("FAIL wrap_col31 got %h want 181f", logv[0]); end
    n_chk++; if (logv[3] !== 13'h1800) begin n_fail++; $display("FAIL wrap_col0 got %h want 1800", logv[3]); end
    scroll_x = 0;
  endtask

  task automatic test_signed;
    line = 8'h80; scroll_y = 8'h90; tile_sel = 0;
    mem[13'h1840] = 8'h80;
    for (int i = 0; i < 16; i++) mem[13'h0800 + i] = 8'hFF;
    run_line(-1);
    n_chk++; if (logv[0] !== 13'h1840) begin n_fail++; $display("FAIL signed_map got %h want 1840", logv[0]); end
    n_chk++; if (logv[1] !== 13'h0800 || logv[2] !== 13'h0801) begin n_fail++; $display("FAIL signed_tile got %h %h want 0800 0801", logv[1], logv[2]); end
    n_chk++; if (logv[4] !== 13'h1000) begin n_fail++; $display("FAIL signed_tile0 got %h want 1000", logv[4]); end
    n_chk++; if (cap_s[0] !== 3 || cap_s[8] !== 0) begin n_fail++; $display("FAIL signed_shade got %0d %0d want 3 0", cap_s[0], cap_s[8]); end
    mem[13'h1840] = 8'h00;
    line = 0; scroll_y = 0; tile_sel = 1;
  endtask

  task automatic test_mid_reset;
    int found, extra;
    found = 0; extra = 0;
    drawline = 1;
    @(posedge clk); #1;
    drawline = 0;
    for (int n = 0; n < 400 && found == 0; n++) begin
      if (pix_valid && pix_x == 8'd50) found = 1;
      else begin @(posedge clk); #1; end
    end
    n_chk++; if (found !== 1) begin n_fail++; $display("FAIL midrst_reach got %0d want 1", found); end
    reset = 1;
    @(posedge clk); #1;
    n_chk++; if (pix_valid !== 1'b0 || render_complete !== 1'b0 || vram_rd !== 1'b0)
      begin n_fail++; $display("FAIL midrst_out got v%b rc%b rd%b want 000", pix_valid, render_complete, vram_rd); end
    reset = 0;
    repeat (30) begin @(posedge clk); #1; if (pix_valid || vram_rd) extra++; end
    n_chk++; if (extra !== 0) begin n_fail++; $display("FAIL midrst_quiet got %0d want 0", extra); end
    run_line(-1);
    e = 0;
    for (int i = 0; i < npix; i++) if (cap_x[i] != i || cap_s[i] != i % 4) e++;
    n_chk++; if (npix !== 160 || cap_x[0] !== 0 || e !== 0)
      begin n_fail++; $display("FAIL midrst_redo npix %0d x0 %0d bad %0d want 160 0 0", npix, cap_x[0], e); end
  endtask

  task automatic test_window;
    win_en = 1; win_y = 0; win_x = 8'd87; win_map_sel = 1;
    run_line(-1);
    e = 0;
`ifdef BG_LINE_RENDERER_WINDOW_EN
    for (int i = 0; i < npix; i++) if (cap_x[i] != i || cap_s[i] != (i < 80 ? i % 4 : 1)) e++;
    n_chk++; if (logv[33] !== 13'h1C00 || logv[36] !== 13'h1C01)
      begin n_fail++; $display("FAIL win_map got %h %h want 1c00 1c01", logv[33], logv[36]); end
`else
    for (int i = 0; i < npix; i++) if (cap_x[i] != i || cap_s[i] != i % 4) e++;
    n_chk++; if (nlog !== 60) begin n_fail++; $display("FAIL win_ignored_reads got %0d want 60", nlog); end
`endif
    n_chk++; if (npix !== 160 || e !== 0) begin n_fail++; $display("FAIL win_seq npix %0d bad %0d want 160 0", npix, e); end
    win_en = 0; win_map_sel = 0;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = (i % 2 == 0) ? 8'h55 : 8'h33;
    for (int i = 0; i < 16; i++) mem[16 + i] = (i % 2 == 0) ? 8'hFF : 8'h00;
    for (int i = 0; i < 32; i++) mem[13'h1C00 + i] = 8'h01;
    test_reset;
    test_basic;
    test_back_to_back;
    test_ignore;
    test_fine_scroll;
    test_map_wrap;
    test_signed;
    test_mid_reset;
    test_window;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
